// File: rtl/spi_master_pkg.sv
// spi_master_pkg: FSM state encodings, SPI mode bit positions and a clog2 helper
// shared by the SPI master and its prescaler.
package spi_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_TRANSFER = 2'd2,
        ST_HOLD     = 2'd3
    } spi_state_e;

    localparam int MODE_CPOL = 1;
    localparam int MODE_CPHA = 0;

    function automatic int spi_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_master_clk_div.sv
// spi_master_clk_div: half-period counter 0..CLK_PRESCALER-1, tick on the last count.
// A clear holds the counter at zero so every phase starts with a full half-period.
module spi_master_clk_div
    import spi_master_pkg::*;
#(
    parameter int CLK_PRESCALER = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (CLK_PRESCALER > 1) ? spi_clog2(CLK_PRESCALER) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PRESCALER - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: full-duplex SPI master with runtime CPOL/CPHA, bit order and one-hot slave select.
// Build option SPI_MASTER_BURST_EN chains a same-slave start in the last HOLD cycle into the next frame.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int  FRAME_LENGTH  = 8,
    parameter int  CLK_PRESCALER = 4,
    parameter int  N_SLAVES      = 1,
    localparam int SS_WIDTH      = (spi_clog2(N_SLAVES) > 1) ? spi_clog2(N_SLAVES) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic                    lsb_first,
    input  logic [SS_WIDTH-1:0]     ss_sel,
    input  logic [FRAME_LENGTH-1:0] tx_data,
    output logic [FRAME_LENGTH-1:0] rx_data,
    output logic                    busy,
    output logic                    done,
    output logic                    sclk,
    output logic                    mosi,
    input  logic                    miso,
    output logic [N_SLAVES-1:0]     ss_n,
    output spi_state_e              dbg_state_o
);
    localparam int IW = spi_clog2(FRAME_LENGTH);
    localparam int EW = IW + 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * FRAME_LENGTH - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(FRAME_LENGTH - 1);

    spi_state_e              state_q, state_d;
    logic [FRAME_LENGTH-1:0] tx_q, tx_d;
    logic [FRAME_LENGTH-1:0] rx_sh_q, rx_sh_d;
    logic [FRAME_LENGTH-1:0] rx_data_q, rx_data_d;
    logic [1:0]              mode_q, mode_d;
    logic                    lsb_q, lsb_d;
    logic [SS_WIDTH-1:0]     ss_q, ss_d;
    logic [EW-1:0]           edge_q, edge_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [N_SLAVES-1:0]     ss_n_q, ss_n_d;

    logic          tick;
    logic          burst_ok;
    logic          load;
    logic          frame_end;
    logic          sample_edge;
    logic [IW-1:0] bit_idx;

    // Position in the frame word of the pos-th bit on the wire.
    function automatic logic [IW-1:0] seq_idx(input logic lsb, input logic [IW-1:0] pos);
        return lsb ? pos : (LAST_BIT - pos);
    endfunction

    spi_master_clk_div #(
        .CLK_PRESCALER(CLK_PRESCALER)
    ) u_clk_div (
        .clk   (clk),
        .rstn  (rstn),
        .en_i  (state_q != ST_IDLE),
        .clr_i (state_q == ST_IDLE),
        .tick_o(tick)
    );

`ifdef SPI_MASTER_BURST_EN
    // A CPOL change needs a real idle gap so the slave sees a clean clock level.
    assign burst_ok = start && (ss_sel == ss_q) && (mode[MODE_CPOL] == mode_q[MODE_CPOL]);
`else
    assign burst_ok = 1'b0;
`endif

    assign frame_end   = (state_q == ST_HOLD) && tick;
    assign load        = ((state_q == ST_IDLE) && start) || (frame_end && burst_ok);
    assign bit_idx     = edge_q[EW-1:1];
    assign sample_edge = (~edge_q[0]) ^ mode_q[MODE_CPHA];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_SETUP;
            ST_SETUP:    if (tick) state_d = ST_TRANSFER;
            ST_TRANSFER: if (tick && (edge_q == LAST_EDGE)) state_d = ST_HOLD;
            ST_HOLD:     if (tick) state_d = burst_ok ? ST_TRANSFER : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_d      = tx_q;
        mode_d    = mode_q;
        lsb_d     = lsb_q;
        ss_d      = ss_q;
        edge_d    = edge_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        ss_n_d    = '1;

        if (state_q != ST_TRANSFER) begin
            edge_d = '0;
        end
        if (state_q == ST_HOLD) begin
            sclk_d = mode_q[MODE_CPOL];
        end
        if ((state_q == ST_TRANSFER) && tick) begin
            sclk_d = ~sclk_q;
            edge_d = (edge_q == LAST_EDGE) ? '0 : edge_q + 1'b1;
            if (sample_edge) begin
                rx_sh_d[seq_idx(lsb_q, bit_idx)] = miso;
            end else if (mode_q[MODE_CPHA]) begin
                mosi_d = tx_q[seq_idx(lsb_q, bit_idx)];
            end else if (bit_idx != LAST_BIT) begin
                mosi_d = tx_q[seq_idx(lsb_q, bit_idx + 1'b1)];
            end
        end
        if (load) begin
            tx_d   = tx_data;
            mode_d = mode;
            lsb_d  = lsb_first;
            ss_d   = ss_sel;
            sclk_d = mode[MODE_CPOL];
            mosi_d = tx_data[seq_idx(lsb_first, '0)];
        end
        if (frame_end) begin
            done_d    = 1'b1;
            rx_data_d = rx_sh_q;
        end

        busy_d = (state_d != ST_IDLE);
        for (int i = 0; i < N_SLAVES; i++) begin
            ss_n_d[i] = !(busy_d && (ss_d == SS_WIDTH'(i)));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_q      <= '0;
            mode_q    <= '0;
            lsb_q     <= 1'b0;
            ss_q      <= '0;
            edge_q    <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ss_n_q    <= '1;
        end else begin
            tx_q      <= tx_d;
            mode_q    <= mode_d;
            lsb_q     <= lsb_d;
            ss_q      <= ss_d;
            edge_q    <= edge_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ss_n_q    <= ss_n_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign ss_n        = ss_n_q;
    assign dbg_state_o = state_q;

endmodule
